// File: rtl/dataflow_pkg.sv
// Shared definitions for the valid/ready dataflow blocks (merge, branch, pipeline registers).
// Covers port count, merge FSM states and the packed-port slice layout.
package dataflow_pkg;

    localparam int DATAFLOW_PORTS = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } merge_state_t;

    // Port k of a packed multi-port bus occupies bits [port_lsb(k, width) +: width].
    function automatic int port_lsb(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/dataflow_register.sv
// Single-entry valid/ready pipeline register carrying data, last and select.
// A new word is accepted whenever the slot is empty or being drained this cycle.
module dataflow_register #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push_last,
    input  logic             push_select,
    input  logic             ready,
    output logic             load,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             last,
    output logic             select
);

    logic             valid_r;
    logic [WIDTH-1:0] data_r;
    logic             last_r;
    logic             select_r;

    assign load   = !valid_r || ready;
    assign valid  = valid_r;
    assign data   = data_r;
    assign last   = last_r;
    assign select = select_r;

    // Output slot: payload only changes when a word is pushed, so it is stable under backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r  <= 1'b0;
            data_r   <= {WIDTH{1'b0}};
            last_r   <= 1'b0;
            select_r <= 1'b0;
        end else if (load) begin
            valid_r <= push;
            if (push) begin
                data_r   <= push_data;
                last_r   <= push_last;
                select_r <= push_select;
            end
        end
    end

endmodule

// File: rtl/dataflow_merge.sv
// Two-input round-robin packet merge: grant is held from the first word of a packet to its
// last word; the output word is registered and tagged with its source index.
module dataflow_merge
    import dataflow_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [DATAFLOW_PORTS*WIDTH-1:0]   i_data,
    input  logic [DATAFLOW_PORTS-1:0]         i_last,
    input  logic [DATAFLOW_PORTS-1:0]         i_valid,
    output logic [DATAFLOW_PORTS-1:0]         i_ready,
    output logic [WIDTH-1:0]                  o_data,
    output logic                              o_last,
    output logic                              o_select,
    output logic                              o_valid,
    input  logic                              o_ready
);

    merge_state_t     state_r;
    merge_state_t     state_nxt_s;
    logic             lock_sel_r;
    logic             lock_sel_nxt_s;
    logic             prio_r;
    logic             prio_nxt_s;
    logic             grant_s;
    logic             load_s;
    logic             xfer_s;
    logic [WIDTH-1:0] word_s;
    logic             last_s;

    // Grant selection: a lone requester wins in IDLE, ties go to prio; a lock overrides everything.
    always_comb begin
        grant_s = prio_r;
        case (state_r)
            IDLE: begin
                if (i_valid == 2'b01) begin
                    grant_s = 1'b0;
                end else if (i_valid == 2'b10) begin
                    grant_s = 1'b1;
                end else begin
                    grant_s = prio_r;
                end
            end
            LOCKED:  grant_s = lock_sel_r;
            default: grant_s = prio_r;
        endcase
    end

    assign i_ready = {load_s && grant_s, load_s && !grant_s};
    assign xfer_s  = load_s && i_valid[grant_s];
    assign word_s  = grant_s ? i_data[port_lsb(1, WIDTH) +: WIDTH]
                             : i_data[port_lsb(0, WIDTH) +: WIDTH];
    assign last_s  = i_last[grant_s];

    // Next-state: the FSM only moves on a transfer, so backpressure freezes it.
    always_comb begin
        state_nxt_s    = state_r;
        lock_sel_nxt_s = lock_sel_r;
        prio_nxt_s     = prio_r;
        if (xfer_s) begin
            case (state_r)
                IDLE: begin
                    if (last_s) begin
                        prio_nxt_s = ~grant_s;
                    end else begin
                        state_nxt_s    = LOCKED;
                        lock_sel_nxt_s = grant_s;
                    end
                end
                LOCKED: begin
                    if (last_s) begin
                        state_nxt_s = IDLE;
                        prio_nxt_s  = ~lock_sel_r;
                    end else begin
                        state_nxt_s = LOCKED;
                    end
                end
                default: state_nxt_s = IDLE;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            lock_sel_r <= 1'b0;
            prio_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            lock_sel_r <= lock_sel_nxt_s;
            prio_r     <= prio_nxt_s;
        end
    end

    dataflow_register #(
        .WIDTH(WIDTH)
    ) u_out_reg (
        .clk        (clk),
        .reset      (reset),
        .push       (xfer_s),
        .push_data  (word_s),
        .push_last  (last_s),
        .push_select(grant_s),
        .ready      (o_ready),
        .load       (load_s),
        .valid      (o_valid),
        .data       (o_data),
        .last       (o_last),
        .select     (o_select)
    );

endmodule

// File: tb/tb_dataflow_merge.sv
// Directed self-checking bench for dataflow_merge: reset, alternation, packet lock,
// backpressure, locked-input gap and mid-packet reset.
module tb_dataflow_merge;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [2*W-1:0] i_data;
    logic [1:0]    i_last;
    logic [1:0]    i_valid;
    logic [1:0]    i_ready;
    logic [W-1:0]  o_data;
    logic          o_last;
    logic          o_select;
    logic          o_valid;
    logic          o_ready;

    int checks = 0;
    int errors = 0;

    dataflow_merge #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_data  (i_data),
        .i_last  (i_last),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_last  (o_last),
        .o_select(o_select),
        .o_valid (o_valid),
        .o_ready (o_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] l,
                         input logic [W-1:0] d0, input logic [W-1:0] d1);
        i_valid = v;
        i_last  = l;
        i_data  = {d1, d0};
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        o_ready = 1'b1;
        drive(2'b00, 2'b00, 32'h0, 32'h0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({o_valid, o_last, o_select, o_data} !== {1'b0, 1'b0, 1'b0, 32'h0}) begin
            $display("FAIL reset_out: got v%b l%b s%b d%h expected all zero", o_valid, o_last, o_select, o_data);
            errors++;
        end
        #1;
        checks++;
        if (i_ready !== 2'b01) begin
            $display("FAIL reset_ready: got %b expected 01", i_ready);
            errors++;
        end
    endtask

    task automatic test_alternation();
        logic [W-1:0] exp_d [4];
        logic         exp_s [4];
        logic [1:0]   exp_r [4];
        logic [W-1:0] n0;
        logic [W-1:0] n1;
        exp_d = '{32'h10, 32'h20, 32'h11, 32'h21};
        exp_s = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_r = '{2'b01, 2'b10, 2'b01, 2'b10};
        n0 = 32'h0;
        n1 = 32'h0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 2'b11, 32'h10 + n0, 32'h20 + n1);
            #1;
            checks++;
            if (i_ready !== exp_r[i]) begin
                $display("FAIL alt_ready[%0d]: got %b expected %b", i, i_ready, exp_r[i]);
                errors++;
            end
            if (exp_r[i][0]) n0 = n0 + 32'h1;
            if (exp_r[i][1]) n1 = n1 + 32'h1;
            tick();
            checks++;
            if ({o_valid, o_last, o_select, o_data} !== {1'b1, 1'b1, exp_s[i], exp_d[i]}) begin
                $display("FAIL alt_out[%0d]: got v%b l%b s%b d%h expected v1 l1 s%b d%h",
                         i, o_valid, o_last, o_select, o_data, exp_s[i], exp_d[i]);
                errors++;
            end
        end
    endtask

    task automatic test_packet_lock();
        logic [1:0]   v [4];
        logic [1:0]   l [4];
        logic [W-1:0] d0 [4];
        logic [W-1:0] d1 [4];
        logic [1:0]   exp_r [4];
        logic         exp_l [4];
        logic         exp_s [4];
        logic [W-1:0] exp_d [4];
        v     = '{2'b01, 2'b11, 2'b11, 2'b10};
        l     = '{2'b00, 2'b10, 2'b11, 2'b10};
        d0    = '{32'hA0, 32'hA1, 32'hA2, 32'h0};
        d1    = '{32'hB0, 32'hB0, 32'hB0, 32'hB0};
        exp_r = '{2'b01, 2'b01, 2'b01, 2'b10};
        exp_l = '{1'b0, 1'b0, 1'b1, 1'b1};
        exp_s = '{1'b0, 1'b0, 1'b0, 1'b1};
        exp_d = '{32'hA0, 32'hA1, 32'hA2, 32'hB0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(v[i], l[i], d0[i], d1[i]);
            #1;
            checks++;
            if (i_ready !== exp_r[i]) begin
                $display("FAIL lock_ready[%0d]: got %b expected %b", i, i_ready, exp_r[i]);
                errors++;
            end
            tick();
            checks++;
            if ({o_valid, o_last, o_select, o_data} !== {1'b1, exp_l[i], exp_s[i], exp_d[i]}) begin
                $display("FAIL lock_out[%0d]: got v%b l%b s%b d%h expected v1 l%b s%b d%h",
                         i, o_valid, o_last, o_select, o_data, exp_l[i], exp_s[i], exp_d[i]);
                errors++;
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(2'b01, 2'b01, 32'hAB, 32'h0);
        tick();
        checks++;
        if ({o_valid, o_data} !== {1'b1, 32'hAB}) begin
            $display("FAIL bp_first: got v%b d%h expected v1 d000000ab", o_valid, o_data);
            errors++;
        end
        o_ready = 1'b0;
        drive(2'b01, 2'b01, 32'hCD, 32'h0);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (i_ready !== 2'b00) begin
                $display("FAIL bp_ready[%0d]: got %b expected 00", i, i_ready);
                errors++;
            end
            tick();
            checks++;
            if ({o_valid, o_last, o_select, o_data} !== {1'b1, 1'b1, 1'b0, 32'hAB}) begin
                $display("FAIL bp_hold[%0d]: got v%b l%b s%b d%h expected v1 l1 s0 d000000ab",
                         i, o_valid, o_last, o_select, o_data);
                errors++;
            end
        end
        o_ready = 1'b1;
        #1;
        checks++;
        if (i_ready !== 2'b01) begin
            $display("FAIL bp_release_ready: got %b expected 01", i_ready);
            errors++;
        end
        tick();
        checks++;
        if ({o_valid, o_select, o_data} !== {1'b1, 1'b0, 32'hCD}) begin
            $display("FAIL bp_next: got v%b s%b d%h expected v1 s0 d000000cd", o_valid, o_select, o_data);
            errors++;
        end
        drive(2'b00, 2'b00, 32'h0, 32'h0);
        tick();
        checks++;
        if (o_valid !== 1'b0) begin
            $display("FAIL bp_drain: got v%b expected v0", o_valid);
            errors++;
        end
    endtask

    task automatic test_locked_gap();
        logic [1:0]   v [5];
        logic [1:0]   l [5];
        logic [W-1:0] d1 [5];
        logic [1:0]   exp_r [5];
        logic         exp_v [5];
        logic         exp_l [5];
        logic         exp_s [5];
        logic [W-1:0] exp_d [5];
        v     = '{2'b10, 2'b01, 2'b01, 2'b11, 2'b01};
        l     = '{2'b00, 2'b01, 2'b01, 2'b11, 2'b01};
        d1    = '{32'hC0, 32'h0, 32'h0, 32'hC1, 32'h0};
        exp_r = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
        exp_v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_s = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_d = '{32'hC0, 32'h0, 32'h0, 32'hC1, 32'h50};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(v[i], l[i], 32'h50, d1[i]);
            #1;
            checks++;
            if (i_ready !== exp_r[i]) begin
                $display("FAIL gap_ready[%0d]: got %b expected %b", i, i_ready, exp_r[i]);
                errors++;
            end
            tick();
            checks++;
            if (exp_v[i]) begin
                if ({o_valid, o_last, o_select, o_data} !== {1'b1, exp_l[i], exp_s[i], exp_d[i]}) begin
                    $display("FAIL gap_out[%0d]: got v%b l%b s%b d%h expected v1 l%b s%b d%h",
                             i, o_valid, o_last, o_select, o_data, exp_l[i], exp_s[i], exp_d[i]);
                    errors++;
                end
            end else begin
                if (o_valid !== 1'b0) begin
                    $display("FAIL gap_idle[%0d]: got v%b expected v0", i, o_valid);
                    errors++;
                end
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        drive(2'b10, 2'b00, 32'h0, 32'hD0);
        tick();
        checks++;
        if ({o_valid, o_last, o_select, o_data} !== {1'b1, 1'b0, 1'b1, 32'hD0}) begin
            $display("FAIL mid_first: got v%b l%b s%b d%h expected v1 l0 s1 d000000d0",
                     o_valid, o_last, o_select, o_data);
            errors++;
        end
        reset = 1'b1;
        drive(2'b11, 2'b11, 32'h60, 32'hD1);
        tick();
        reset = 1'b0;
        checks++;
        if ({o_valid, o_last, o_select, o_data} !== {1'b0, 1'b0, 1'b0, 32'h0}) begin
            $display("FAIL mid_reset: got v%b l%b s%b d%h expected all zero", o_valid, o_last, o_select, o_data);
            errors++;
        end
        #1;
        checks++;
        if (i_ready !== 2'b01) begin
            $display("FAIL mid_ready: got %b expected 01", i_ready);
            errors++;
        end
        tick();
        checks++;
        if ({o_valid, o_last, o_select, o_data} !== {1'b1, 1'b1, 1'b0, 32'h60}) begin
            $display("FAIL mid_after: got v%b l%b s%b d%h expected v1 l1 s0 d00000060",
                     o_valid, o_last, o_select, o_data);
            errors++;
        end
    endtask

    initial begin
        reset   = 1'b1;
        o_ready = 1'b1;
        drive(2'b00, 2'b00, 32'h0, 32'h0);
        test_reset();
        test_alternation();
        test_packet_lock();
        test_backpressure();
        test_locked_gap();
        test_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dataflow_merge.md
Name: dataflow_merge

Overview:
- Two-input to one-output merge for valid/ready dataflow streams; the counterpart of the branch switch.
- Recombines streams previously split by select, e.g. left/right channel paths feeding a common level-meter or output stage.
- Arbitrates round-robin between inputs and holds the grant for a whole packet, delimited by a last flag.
- Output is registered; o_select reports which input each word came from, so a downstream branch can re-split.

Parameters:
WIDTH, 32, data bits per word on each input and on the output.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
i_data  input  2*WIDTH  input words; port k occupies bits [k*WIDTH +: WIDTH]
i_last  input  2  per-input end-of-packet flag, qualified by i_valid
i_valid  input  2  per-input valid
i_ready  output  2  per-input ready
o_data  output  WIDTH  merged output word (registered)
o_last  output  1  end-of-packet flag of output word (registered)
o_select  output  1  source index of output word (registered)
o_valid  output  1  output valid (registered)
o_ready  input  1  downstream ready

Behaviour:
- Reset: o_valid=0, o_data=0, o_last=0, o_select=0, state=IDLE, prio=0. Reset mid-packet discards the held output word and any lock.
- load = !o_valid || o_ready. The output register accepts a new word only when load is 1.
- grant (1 bit, combinational):
  - IDLE, both i_valid set: grant=prio.
  - IDLE, one i_valid set: grant=that input.
  - IDLE, no i_valid set: grant=prio (irrelevant).
  - LOCKED: grant=lock_sel, regardless of the other input's valid.
- i_ready[k] = load && (grant==k). Never both set. i_ready may depend on i_valid in IDLE only.
- Transfer on port g = i_valid[g] && i_ready[g]. On transfer, next cycle: o_valid=1, o_data=word g, o_last=i_last[g], o_select=g.
- If load=1 with no transfer: o_valid=0 next cycle; o_data/o_last/o_select may hold.
- While o_valid && !o_ready, o_data, o_last and o_select are stable.
- State transitions, evaluated on transfer only:
  - IDLE, last=0: go LOCKED, lock_sel=g.
  - IDLE, last=1: stay IDLE, prio=~g.
  - LOCKED, last=0: stay LOCKED.
  - LOCKED, last=1: go IDLE, prio=~lock_sel.
- Latency: 1 cycle input-to-output. Throughput: 1 word/cycle with o_ready held high, including during a grant switch (no bubble).
- Starvation bound: with both inputs continuously valid, each packet from one input is followed by at most one packet from the other.
- A locked input may deassert i_valid mid-packet. The lock holds and the other input waits.
- Backpressure: o_ready=0 with o_valid=1 forces both i_ready=0. The state machine freezes.

Decomposition:
- Shared package dataflow_pkg:
  - localparam DATAFLOW_PORTS=2.
  - typedef enum merge_state_t {IDLE, LOCKED}.
  - Port-slice helper constant/function for the packed i_data layout.
- Natural sub-module dataflow_register: a single-entry valid/ready pipeline register (data+last+select payload, load = !valid || ready). This merge and later blocks reuse it.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, all valid low -> o_valid=0, o_data=0, o_select=0, i_ready=2'b01 (grant=prio=0, load=1).
- Single-word alternation: both inputs always valid, last=1, port0 data 0x10,0x11,... and port1 data 0x20,0x21,...; o_ready=1 -> output sequence 0x10,0x20,0x11,0x21 with o_select 0,1,0,1, no bubbles.
- Packet lock: port0 sends 3-word packet (A0,A1,A2 with last on A2) while port1 is valid from cycle 1 -> output A0,A1,A2 then port1 word. i_ready[1]=0 throughout the packet.
- Backpressure: o_ready=0 for 4 cycles while o_valid=1 holding 0xAB -> o_data stays 0xAB, i_ready=2'b00. After release, the next word appears 1 cycle later.
- Locked-input gap: port1 in LOCKED drops i_valid for 2 cycles mid-packet while port0 is valid -> i_ready[0] stays 0, no port0 word is emitted until port1's last word transfers.
- Reset mid-packet: assert reset during LOCKED with o_valid=1 -> next cycle o_valid=0, state IDLE, prio=0. Then both inputs valid -> port0 granted first.
